// File: rtl/vector_exec_pkg.sv
// vector_exec_pkg: shared lane geometry, ALU opcodes and stage FSM states.
// Contents: LANE_W, LANES, LANES_PER_CYCLE, DATA_W, OP_* lane operations, state_t.
package vector_exec_pkg;
    localparam int LANE_W = 8;
    localparam int LANES = 6;
    localparam int LANES_PER_CYCLE = 2;
    localparam int DATA_W = LANE_W * LANES;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: combinational 8-bit lane add/sub/and/or.
// Ports: a, b lane operands; op lane operation; y lane result.
// VECTOR_EXEC_SAT_EN: add clamps to 0xFF on overflow, sub clamps to 0x00 on underflow.
module vector_lane_alu
    import vector_exec_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [1:0]        op,
    output logic [LANE_W-1:0] y
);
    logic [LANE_W-1:0] add_r, sub_r;
`ifdef VECTOR_EXEC_SAT_EN
    logic [LANE_W:0] sum, diff;
    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign add_r = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
    assign sub_r = diff[LANE_W] ? '0 : diff[LANE_W-1:0];
`else
    assign add_r = a + b;
    assign sub_r = a - b;
`endif
    always_comb y = op == OP_ADD ? add_r : op == OP_SUB ? sub_r : op == OP_AND ? a & b : a | b;
endmodule

// File: rtl/vector_exec_stage.sv
// vector_exec_stage: multi-cycle 6x8-bit vector execute stage, two lanes per cycle.
// Ports: clk, rst (sync, active high); decode-side operands/control with validE/readyE
// handshake; memory-side captured control, lane-wise ALUResultM, zeroM and validM pulse.
// VECTOR_EXEC_SAT_EN selects saturating add/sub in the lane ALUs.
module vector_exec_stage
    import vector_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [DATA_W-1:0] ExtImm,
    input  logic [3:0]        WA3E,
    input  logic [3:0]        opcodeE,
    input  logic              regWriteE,
    input  logic              aluSrcE,
    input  logic              PCSrcE,
    input  logic              memToRegE,
    input  logic              memWriteE,
    input  logic [1:0]        aluControlE,
    input  logic              validE,
    output logic              readyE,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [3:0]        WA3M,
    output logic [3:0]        opcodeM,
    output logic              regWriteM,
    output logic              memToRegM,
    output logic              memWriteM,
    output logic              PCSrcM,
    output logic              zeroM,
    output logic              validM
);
    state_t state;
    logic [1:0] cnt, ctl;
    logic [DATA_W-1:0] a_r, b_r;
    logic reg_write_r, mem_write_r, pc_src_r;
    logic [LANE_W-1:0] y_lo, y_hi;
    logic [5:0] base;
    logic accept;
    assign readyE = state != BUSY;
    assign validM = state == DONE;
    assign accept = validE & readyE;
    assign zeroM = ~|ALUResultM;
    assign regWriteM = reg_write_r & validM;
    assign memWriteM = mem_write_r & validM;
    assign PCSrcM = pc_src_r & validM;
    // Bit offset of the lane pair handled this cycle: 2 lanes x 8 bits per step.
    assign base = {cnt, 4'b0000};
    vector_lane_alu u_lo (.a(a_r[base +: LANE_W]), .b(b_r[base +: LANE_W]), .op(ctl), .y(y_lo));
    vector_lane_alu u_hi (.a(a_r[base + 6'd8 +: LANE_W]), .b(b_r[base + 6'd8 +: LANE_W]), .op(ctl), .y(y_hi));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            ctl <= '0;
            a_r <= '0;
            b_r <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M <= '0;
            opcodeM <= '0;
            reg_write_r <= 1'b0;
            memToRegM <= 1'b0;
            mem_write_r <= 1'b0;
            pc_src_r <= 1'b0;
        end else if (accept) begin
            state <= BUSY;
            cnt <= '0;
            ctl <= aluControlE;
            a_r <= SrcA;
            b_r <= aluSrcE ? ExtImm : SrcB;
            WriteDataM <= SrcB;
            WA3M <= WA3E;
            opcodeM <= opcodeE;
            reg_write_r <= regWriteE;
            memToRegM <= memToRegE;
            mem_write_r <= memWriteE;
            pc_src_r <= PCSrcE;
        end else if (state == BUSY) begin
            ALUResultM[base +: LANE_W] <= y_lo;
            ALUResultM[base + 6'd8 +: LANE_W] <= y_hi;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd2) state <= DONE;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_vector_exec_stage.sv
// tb_vector_exec_stage: directed self-checking bench for vector_exec_stage.
module tb_vector_exec_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic [47:0] SrcA = '0, SrcB = '0, ExtImm = '0;
    logic [3:0] WA3E = '0, opcodeE = '0;
    logic regWriteE = 0, aluSrcE = 0, PCSrcE = 0, memToRegE = 0, memWriteE = 0, validE = 0;
    logic [1:0] aluControlE = '0;
    logic readyE, regWriteM, memToRegM, memWriteM, PCSrcM, zeroM, validM;
    logic [47:0] ALUResultM, WriteDataM;
    logic [3:0] WA3M, opcodeM;
    int checks = 0, errors = 0;

    vector_exec_stage dut (
        .clk(clk), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .ExtImm(ExtImm),
        .WA3E(WA3E), .opcodeE(opcodeE), .regWriteE(regWriteE), .aluSrcE(aluSrcE),
        .PCSrcE(PCSrcE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .aluControlE(aluControlE), .validE(validE), .readyE(readyE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .opcodeM(opcodeM),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .PCSrcM(PCSrcM), .zeroM(zeroM), .validM(validM)
    );

    always #5 clk = ~clk;

    task automatic set_op(input [47:0] a, b, imm, input src, input [1:0] ctl,
                          input rw, mw, pcs, m2r, input [3:0] wa, op);
        SrcA = a; SrcB = b; ExtImm = imm; aluSrcE = src; aluControlE = ctl;
        regWriteE = rw; memWriteE = mw; PCSrcE = pcs; memToRegE = m2r; WA3E = wa; opcodeE = op;
    endtask

    // Presents one op for a single edge; returns at the negedge after the accept edge.
    task automatic drive(input [47:0] a, b, imm, input src, input [1:0] ctl,
                         input rw, mw, pcs, m2r, input [3:0] wa, op);
        @(negedge clk);
        set_op(a, b, imm, src, ctl, rw, mw, pcs, m2r, wa, op);
        validE = 1'b1;
        @(negedge clk);
        validE = 1'b0;
    endtask

    // Negedge count after the accept edge at which validM is first seen (12 = timeout).
    task automatic wait_valid(output int n);
        n = 1;
        while (!validM && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (readyE !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", readyE); end
        checks++; if (validM !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", validM); end
        checks++; if (ALUResultM !== 48'h0 || WA3M !== 4'h0 || WriteDataM !== 48'h0)
            begin errors++; $display("FAIL reset_outputs: got %h/%h/%h expected zeros", ALUResultM, WA3M, WriteDataM); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int n;
        drive(48'h010203040506, 48'h010101010101, 48'hAAAAAAAAAAAA, 0, 2'b00, 1, 0, 0, 0, 4'h3, 4'h5);
        wait_valid(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", n); end
        checks++; if (ALUResultM !== 48'h020304050607) begin errors++; $display("FAIL add_result: got %h expected 020304050607", ALUResultM); end
        checks++; if (zeroM !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", zeroM); end
        checks++; if (WA3M !== 4'h3 || opcodeM !== 4'h5 || WriteDataM !== 48'h010101010101)
            begin errors++; $display("FAIL add_capture: got %h/%h/%h expected 3/5/010101010101", WA3M, opcodeM, WriteDataM); end
        @(negedge clk);
        checks++; if (validM !== 1'b0 || ALUResultM !== 48'h020304050607)
            begin errors++; $display("FAIL add_hold: got %b/%h expected 0/020304050607", validM, ALUResultM); end
    endtask

    task automatic test_overflow;
        int n;
        logic [47:0] e_add, e_sub;
`ifdef VECTOR_EXEC_SAT_EN
        e_add = 48'hFF01FF01FF01;
        e_sub = 48'h000000000000;
`else
        e_add = 48'h000100010001;
        e_sub = 48'hFFFFFFFFFFFF;
`endif
        drive(48'hFF00FF00FF00, 48'h010101010101, 48'h0, 0, 2'b00, 0, 0, 0, 0, 4'h1, 4'h1);
        wait_valid(n);
        checks++; if (n !== 4 || ALUResultM !== e_add) begin errors++; $display("FAIL ovf_add: got %0d/%h expected 4/%h", n, ALUResultM, e_add); end
        drive(48'h000000000000, 48'h010101010101, 48'h0, 0, 2'b01, 0, 0, 0, 0, 4'h1, 4'h1);
        wait_valid(n);
        checks++; if (n !== 4 || ALUResultM !== e_sub) begin errors++; $display("FAIL ovf_sub: got %0d/%h expected 4/%h", n, ALUResultM, e_sub); end
    endtask

    task automatic test_imm_sub;
        logic [3:0] rv;
        logic [3:0] vv;
        drive(48'h050505050505, 48'h0A0A0A0A0A0A, 48'h050505050505, 1, 2'b01, 0, 0, 0, 0, 4'h2, 4'h2);
        for (int i = 0; i < 4; i++) begin
            rv[i] = readyE;
            vv[i] = validM;
            if (i < 3) @(negedge clk);
        end
        checks++; if (rv !== 4'b1000) begin errors++; $display("FAIL sub_ready: got %b expected 1000", rv); end
        checks++; if (vv !== 4'b1000) begin errors++; $display("FAIL sub_valid: got %b expected 1000", vv); end
        checks++; if (ALUResultM !== 48'h0 || zeroM !== 1'b1) begin errors++; $display("FAIL sub_zero: got %h/%b expected 0/1", ALUResultM, zeroM); end
        checks++; if (WriteDataM !== 48'h0A0A0A0A0A0A) begin errors++; $display("FAIL sub_wdata: got %h expected 0a0a0a0a0a0a", WriteDataM); end
    endtask

    task automatic test_back_to_back;
        int k1 = 0, k2 = 0, pulses = 0;
        logic [47:0] r1 = '0, r2 = '0;
        @(negedge clk);
        set_op(48'hF0F0F0F0F0F0, 48'h3C3C3C3C3C3C, 48'h0, 0, 2'b10, 0, 0, 0, 0, 4'h4, 4'h4);
        validE = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) set_op(48'h0F0F0F0F0F0F, 48'h101010101010, 48'h0, 0, 2'b11, 0, 0, 0, 0, 4'h6, 4'h6);
            if (k == 5) validE = 1'b0;
            if (validM) begin
                pulses++;
                if (pulses == 1) begin k1 = k; r1 = ALUResultM; end
                else begin k2 = k; r2 = ALUResultM; end
            end
        end
        validE = 1'b0;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (k1 !== 4 || k2 !== 8) begin errors++; $display("FAIL b2b_timing: got %0d/%0d expected 4/8", k1, k2); end
        checks++; if (r1 !== 48'h303030303030) begin errors++; $display("FAIL b2b_and: got %h expected 303030303030", r1); end
        checks++; if (r2 !== 48'h1F1F1F1F1F1F) begin errors++; $display("FAIL b2b_or: got %h expected 1f1f1f1f1f1f", r2); end
    endtask

    task automatic test_reset_mid;
        int n, seen = 0;
        drive(48'h111111111111, 48'h222222222222, 48'h0, 0, 2'b00, 1, 1, 0, 0, 4'h9, 4'h9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (readyE !== 1'b1 || validM !== 1'b0) begin errors++; $display("FAIL rstmid_state: got %b/%b expected 1/0", readyE, validM); end
        checks++; if (ALUResultM !== 48'h0 || WA3M !== 4'h0 || WriteDataM !== 48'h0)
            begin errors++; $display("FAIL rstmid_outputs: got %h/%h/%h expected zeros", ALUResultM, WA3M, WriteDataM); end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (validM) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_nopulse: got %0d pulses expected 0", seen); end
        drive(48'h101010101010, 48'h020202020202, 48'h0, 0, 2'b00, 0, 0, 0, 0, 4'h7, 4'h7);
        wait_valid(n);
        checks++; if (n !== 4 || ALUResultM !== 48'h121212121212) begin errors++; $display("FAIL rstmid_fresh: got %0d/%h expected 4/121212121212", n, ALUResultM); end
    endtask

    task automatic test_gating;
        logic early = 1'b0;
        drive(48'h1, 48'h1, 48'h0, 0, 2'b00, 1, 1, 1, 1, 4'h8, 4'h8);
        for (int i = 1; i < 4; i++) begin
            early |= regWriteM | memWriteM | PCSrcM;
            @(negedge clk);
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL gate_early: got %b expected 0", early); end
        checks++; if ({validM, regWriteM, memWriteM, PCSrcM, memToRegM} !== 5'b11111)
            begin errors++; $display("FAIL gate_pulse: got %b expected 11111", {validM, regWriteM, memWriteM, PCSrcM, memToRegM}); end
        @(negedge clk);
        checks++; if ({regWriteM, memWriteM, PCSrcM, memToRegM} !== 4'b0001)
            begin errors++; $display("FAIL gate_after: got %b expected 0001", {regWriteM, memWriteM, PCSrcM, memToRegM}); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_overflow;
        test_imm_sub;
        test_back_to_back;
        test_reset_mid;
        test_gating;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_exec_stage.md
VECTOR_EXEC_STAGE -- requirements
Module: vector_exec_stage

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; ports listed clock and reset first:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 SrcA, SrcB, ExtImm  input  48 each  operands from decode/execute register; 6 lanes x 8 bits, lane i = bits [8i+7:8i].
REQ-005 WA3E, opcodeE  input  4 each  destination register and opcode.
REQ-006 regWriteE, aluSrcE, PCSrcE, memToRegE, memWriteE  input  1 each  control bits.
REQ-007 aluControlE  input  2  lane operation: 00 add, 01 sub, 10 and, 11 or.
REQ-008 validE  input  1  operation present on inputs.
REQ-009 readyE  output  1  stage can accept; upstream holds its register while low.
REQ-010 ALUResultM  output  48  lane-wise result.
REQ-011 WriteDataM  output  48  captured SrcB.
REQ-012 WA3M, opcodeM  output  4 each  captured WA3E, opcodeE.
REQ-013 regWriteM, memToRegM, memWriteM, PCSrcM  output  1 each  captured control.
REQ-014 zeroM  output  1  ALUResultM == 0.
REQ-015 validM  output  1  one-cycle pulse, result complete.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 readyE SHALL be 1 in IDLE and DONE, 0 in BUSY (combinational from state).
REQ-018 Accept = validE & readyE at a clock edge: capture SrcA, operand B (aluSrcE ? ExtImm : SrcB), SrcB, WA3E, opcodeE, control bits, aluControlE; clear lane counter; go BUSY.
REQ-019 BUSY SHALL compute 2 lanes per cycle: counter c = 0,1,2 computes lanes 2c and 2c+1 into the result register; at c == 2 go DONE.
REQ-020 Latency: accept at edge N -> validM = 1 for exactly the cycle after edge N+3.
REQ-021 DONE with accept SHALL go BUSY; DONE without accept SHALL go IDLE; validM = 1 only in DONE.
REQ-022 Add/sub SHALL be 8-bit per lane, modulo 256, no inter-lane carry; and/or bitwise.
REQ-023 regWriteM, memWriteM, PCSrcM SHALL be the captured bit AND validM; other outputs hold last captured/computed values between pulses.
REQ-024 zeroM SHALL be valid whenever validM = 1.
REQ-025 Inputs in BUSY SHALL be ignored regardless of validE.

Reset
REQ-026 rst SHALL force IDLE, counter 0, all registered outputs 0, validM 0; readyE = 1 the cycle after reset.
REQ-027 rst during BUSY or DONE SHALL abort the operation with no validM pulse.
REQ-028 rst has priority over accept at the same edge.

Configuration
REQ-029 Macro VECTOR_EXEC_SAT_EN defined: add clamps each lane to 0xFF on unsigned overflow, sub clamps to 0x00 on underflow.
REQ-030 Macro undefined: wrap-around per REQ-022; and/or unaffected either way.

Structure
REQ-031 Shared package vector_exec_pkg SHALL hold: state enum, LANE_W = 8, LANES = 6, LANES_PER_CYCLE = 2, ALU op constants.
REQ-032 Sub-module vector_lane_alu SHALL be the combinational 8-bit lane operation (including saturation), instantiated twice.

Verification
REQ-033 Add: SrcA = 0x010203040506, SrcB = 0x010101010101, aluSrcE = 0, ctrl 00 -> ALUResultM = 0x020304050607, validM 4 cycles after accept, zeroM = 0.
REQ-034 Lane overflow: SrcA = 0xFF00FF00FF00, SrcB = 0x010101010101, add -> 0x000100010001 without macro; 0xFF01FF01FF01 with VECTOR_EXEC_SAT_EN.
REQ-035 Immediate sub: SrcA = 0x050505050505, ExtImm = 0x050505050505, aluSrcE = 1, ctrl 01 -> result 0, zeroM = 1; readyE low for 3 cycles.
REQ-036 Back-to-back: validE held high with two ops (and, or) -> second accepted in DONE of first; validM pulses 4 cycles apart, with correct results.
REQ-037 Reset mid-op: rst in second BUSY cycle -> no validM, outputs 0, readyE = 1 next cycle, then a fresh add completes normally.
REQ-038 Gating: regWriteE = memWriteE = 1 accepted -> regWriteM, memWriteM high only during the validM cycle.
